tx_fifo_arbiter: RTL and testbench
==================================

# tx_fifo_arbiter

Two-source packet arbiter that drains two 4-deep byte FIFOs, the DHT11 report FIFO (source 0) and the SR04 report FIFO (source 1), into the single UART transmitter. It grants one source at a time and holds the grant until that source's message is complete. Grants alternate round-robin so neither sensor starves. The FIFOs are first-word-fall-through: pop data is valid while not empty, and a pop advances the read pointer on the next clock edge.

## Interface
- EOP_BYTE, 8'h0A, end-of-packet delimiter; the grant is released after this byte is sent.
- MAX_BURST, 16, maximum bytes per grant (1..255); the grant is released once this count is reached.
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- empty0  input  1  source-0 FIFO empty flag
- data0  input  8  source-0 FIFO pop data
- pop0  output  1  source-0 FIFO pop strobe, one-cycle pulse
- empty1  input  1  source-1 FIFO empty flag
- data1  input  8  source-1 FIFO pop data
- pop1  output  1  source-1 FIFO pop strobe, one-cycle pulse
- tx_busy  input  1  UART transmitter busy; goes high on the cycle after tx_start and stays high until the byte is shifted out
- tx_start  output  1  UART start strobe, one-cycle pulse
- tx_data  output  8  byte to transmit; registered and stable from tx_start until the next tx_start
- grant  output  2  one-hot owner (01 = source 0, 10 = source 1, 00 = none)

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- Registered state: last grant `last` (reset 1), burst counter `cnt` (8 bit, reset 0).
- IDLE
  - Request vector is req = {~empty1, ~empty0}.
  - If both sources request, pick the source that is not `last`. If one requests, pick it.
  - On the selecting edge: set grant, load tx_data from the chosen FIFO's data, set cnt to 1, go to ISSUE.
- ISSUE (exactly one cycle)
  - Assert tx_start and pop of the granted source, both for this cycle only.
  - Go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. No timeout.
- WAIT_DONE: wait for tx_busy=0. On that edge, evaluate the release conditions below:
  - Release if the sent byte equals EOP_BYTE, or cnt==MAX_BURST, or the granted FIFO is empty.
  - Release: go to IDLE, set last to the granted index, clear grant, clear cnt.
  - Otherwise: load tx_data from the granted FIFO's data, increment cnt, go to ISSUE.
- The non-granted FIFO is never popped while a grant is held, even if it is not empty.
- Pop is never asserted toward an empty FIFO. The empty flag is sampled at the IDLE or WAIT_DONE decision edge, and the FIFO flag has already settled by then.
- The sent byte used for the EOP compare is tx_data, the registered copy.
- Reset values: pop0=0, pop1=0, tx_start=0, tx_data=8'h00, grant=2'b00, state=IDLE.
- Reset mid-operation: all outputs take their reset values immediately and asynchronously. An in-flight byte is abandoned; FIFO contents are not touched by this block.

## Timing
- Request to start: the FIFO goes non-empty in cycle N (seen in IDLE), and tx_start and pop are high in cycle N+1.
- Back-to-back bytes: tx_busy falls in cycle M, and the next tx_start occurs in cycle M+1.
- Per-byte overhead beyond the UART frame: 3 cycles (ISSUE, ACK edge, DONE edge).
- Release to new grant: at least 2 cycles. The release edge enters IDLE; the next edge selects and enters ISSUE.
- tx_start and pop are single-cycle and coincident; never high for two consecutive cycles.
- grant is stable from the selecting edge through the release edge.

## Test plan
- Single source: load "T=25\n" (5 bytes) into FIFO0 with FIFO1 empty.
  - Expect 5 tx_start pulses carrying 54,3D,32,35,0A and 5 pop0 pulses with pop1=0.
  - Expect grant 01 throughout, then 00 after the 0A byte completes.
- Contention after reset: both FIFOs non-empty in the same cycle.
  - Expect source 0 granted first (last=1 at reset). After its 0A, source 1 is granted.
  - In a second contention round, source 0 is granted again.
- No interleave: FIFO1 is filled mid-packet while source 0 holds the grant.
  - Expect no pop1 until source 0 sends its 0A.
  - Expect source 1 to start no earlier than 2 cycles after the release.
- MAX_BURST=3: FIFO0 holds 6 bytes with no 0A and FIFO1 holds "A\n".
  - Expect 3 source-0 bytes, then source 1's 41,0A, then the remaining 3 source-0 bytes.
- Underflow: FIFO0 holds 2 bytes with no delimiter.
  - Expect the grant released after byte 2 with no third pop.
  - Push a 3rd byte later: expect a new grant and tx_start 1 cycle after empty0 falls.
- Reset mid-byte: assert rst while in WAIT_DONE.
  - Expect grant=00, tx_start=0 and pops=0 immediately.
  - After rst falls with data pending: expect a normal restart with source 0 having priority.

Source files
------------

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: round-robin packet arbiter that drains two FWFT
// sensor report FIFOs into one UART transmitter, one message per grant.
module tx_fifo_arbiter #(
   parameter logic [7:0] EOP_BYTE  = 8'h0A,
   parameter int         MAX_BURST = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       empty0,
   input  logic [7:0] data0,
   output logic       pop0,
   input  logic       empty1,
   input  logic [7:0] data1,
   output logic       pop1,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [1:0] grant
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

   state_t     state;
   logic       last;
   logic       owner;
   logic [7:0] cnt;

   logic       any_req;
   logic       sel;
   logic [7:0] sel_data;
   logic       own_empty;
   logic [7:0] own_data;
   logic       release_now;

   // Ties go to the source that did not own the previous grant.
   always_comb begin
      any_req  = ~empty0 | ~empty1;
      sel      = ~empty1;
      if (~empty0 & ~empty1)
         sel = ~last;
      sel_data = sel ? data1 : data0;
      own_empty = owner ? empty1 : empty0;
      own_data  = owner ? data1 : data0;
      release_now = (tx_data == EOP_BYTE) ||
                    (cnt == BURST_LIM) ||
                    own_empty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         owner    <= 1'b0;
         cnt      <= 8'd0;
         pop0     <= 1'b0;
         pop1     <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         grant    <= 2'b00;
      end else begin
         tx_start <= 1'b0;
         pop0     <= 1'b0;
         pop1     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner    <= sel;
                  grant    <= sel ? 2'b10 : 2'b01;
                  tx_data  <= sel_data;
                  cnt      <= 8'd1;
                  tx_start <= 1'b1;
                  pop0     <= ~sel;
                  pop1     <= sel;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (tx_busy)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (release_now) begin
                     last  <= owner;
                     grant <= 2'b00;
                     cnt   <= 8'd0;
                     state <= IDLE;
                  end else begin
                     tx_data  <= own_data;
                     cnt      <= cnt + 8'd1;
                     tx_start <= 1'b1;
                     pop0     <= ~owner;
                     pop1     <= owner;
                     state    <= ISSUE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: FIFO/UART environment with a message-level
// reference model feeding a scoreboard checked by a monitor.
module tb_tx_fifo_arbiter;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic       src;
      logic [7:0] b;
      int         kind;
   } item_t;

   localparam int K_START   = 0;
   localparam int K_NEXT    = 1;
   localparam int K_REGRANT = 2;
   localparam logic [7:0] EOP = 8'h0A;
   localparam int MAXB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       empty0 = 1'b1;
   logic       empty1 = 1'b1;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic       tx_busy = 1'b0;
   logic       pop0;
   logic       pop1;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] grant;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int rst_fall_cyc = 0;
   int efall0 = 0;
   int efall1 = 0;
   int scn_cnt = 0;
   int inj_k = -1;
   logic inj_src = 1'b0;
   bq_t inj_q;
   bq_t s0q, s1q, f0q, f1q, none;
   item_t expq[$];
   item_t mit;
   logic m_last = 1'b1;
   logic prev_start = 1'b0;
   logic [1:0] prev_grant = 2'b00;

   tx_fifo_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .empty0   (empty0),
      .data0    (data0),
      .pop0     (pop0),
      .empty1   (empty1),
      .data1    (data1),
      .pop1     (pop1),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .grant    (grant)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic bq_t sq(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++)
         q.push_back(s[i]);
      return q;
   endfunction

   function automatic logic [7:0] rnd_byte(input bit allow_eop);
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (allow_eop && $urandom_range(0, 5) == 0)
         b = EOP;
      if (!allow_eop && b == EOP)
         b = 8'h55;
      return b;
   endfunction

   // Message-level model: a grant sends bytes until EOP, burst limit,
   // or the owner's queue runs dry; ties alternate away from the last owner.
   task automatic model(input bq_t a0, input bq_t a1, input int k,
                        input logic isrc, input bq_t ib);
      bq_t q0 = a0;
      bq_t q1 = a1;
      int sent = 0;
      int c;
      bit first = 1;
      bit rel;
      logic g;
      logic [7:0] b;
      item_t it;
      while (q0.size() + q1.size() != 0) begin
         if (q0.size() != 0 && q1.size() != 0)
            g = ~m_last;
         else
            g = (q1.size() != 0);
         c = 0;
         rel = 0;
         while (!rel) begin
            if (g) b = q1.pop_front();
            else b = q0.pop_front();
            c++;
            sent++;
            it.src = g;
            it.b = b;
            it.kind = (c > 1) ? K_NEXT : (first ? K_START : K_REGRANT);
            expq.push_back(it);
            if (sent == k) begin
               foreach (ib[i]) begin
                  if (isrc) q1.push_back(ib[i]);
                  else q0.push_back(ib[i]);
               end
            end
            rel = (b == EOP) || (c == MAXB) ||
                  (g ? q1.size() == 0 : q0.size() == 0);
         end
         first = 0;
         m_last = g;
      end
   endtask

   // FWFT FIFOs, depth 4, topped up from per-source byte streams.
   initial forever begin
      @(negedge clk);
      if (!rst && pop0) begin
         chk("pop0_nonempty", int'(f0q.size() != 0), 1);
         if (f0q.size() != 0) void'(f0q.pop_front());
      end
      if (!rst && pop1) begin
         chk("pop1_nonempty", int'(f1q.size() != 0), 1);
         if (f1q.size() != 0) void'(f1q.pop_front());
      end
      if (s0q.size() != 0 && f0q.size() < 4) f0q.push_back(s0q.pop_front());
      if (s1q.size() != 0 && f1q.size() < 4) f1q.push_back(s1q.pop_front());
      if (empty0 && f0q.size() != 0) efall0 = cyc;
      if (empty1 && f1q.size() != 0) efall1 = cyc;
      empty0 = (f0q.size() == 0);
      empty1 = (f1q.size() == 0);
      data0 = empty0 ? 8'h00 : f0q[0];
      data1 = empty1 ? 8'h00 : f1q[0];
   end

   // UART: busy rises the cycle after tx_start and holds for a random frame.
   initial begin
      int left;
      left = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tx_busy = 1'b0;
            left = 0;
         end else if (tx_start) begin
            left = $urandom_range(3, 6);
         end else if (left > 0) begin
            tx_busy = 1'b1;
            left--;
         end else begin
            if (tx_busy) fall_cyc = cyc;
            tx_busy = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on every tx_start.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_start = 1'b0;
         prev_grant = 2'b00;
      end else begin
         if (prev_grant != 2'b00 && grant != 2'b00)
            chk("grant_hold", int'(grant), int'(prev_grant));
         if (tx_start) begin
            int ef;
            int want;
            chk("start_gap", int'(prev_start), 0);
            scn_cnt++;
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_start actual=%0h required=none",
                        tx_data);
            end else begin
               mit = expq.pop_front();
               chk("tx_data", int'(tx_data), int'(mit.b));
               chk("grant", int'(grant), mit.src ? 2 : 1);
               chk("pop", int'({pop1, pop0}), mit.src ? 2 : 1);
               if (mit.kind == K_NEXT) begin
                  want = fall_cyc + 1;
               end else if (mit.kind == K_REGRANT) begin
                  want = fall_cyc + 2;
               end else begin
                  ef = mit.src ? efall1 : efall0;
                  want = ((ef > rst_fall_cyc) ? ef : rst_fall_cyc) + 1;
               end
               chk("start_latency", cyc, want);
            end
            if (scn_cnt == inj_k) begin
               foreach (inj_q[i]) begin
                  if (inj_src) s1q.push_back(inj_q[i]);
                  else s0q.push_back(inj_q[i]);
               end
            end
         end else begin
            chk("stray_pop", int'({pop1, pop0}), 0);
         end
         prev_start = tx_start;
         prev_grant = grant;
      end
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((expq.size() != 0 || grant != 2'b00) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drained"}, expq.size(), 0);
      chk({nm, "_released"}, int'(grant), 0);
      chk({nm, "_fifos_empty"},
          f0q.size() + f1q.size() + s0q.size() + s1q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_scn(input string nm, input bq_t a0, input bq_t a1,
                          input int k, input logic isrc, input bq_t ib);
      @(negedge clk);
      scn_cnt = 0;
      inj_k = k;
      inj_src = isrc;
      inj_q = ib;
      model(a0, a1, k, isrc, ib);
      foreach (a0[i]) s0q.push_back(a0[i]);
      foreach (a1[i]) s1q.push_back(a1[i]);
      wait_idle(nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t a0, a1, ib, b0, b1;
      int n;
      repeat (2) @(negedge clk);
      chk("rst_grant", int'(grant), 0);
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_pops", int'({pop1, pop0}), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      @(negedge clk);
      rst = 1'b0;
      rst_fall_cyc = cyc;

      run_scn("contend1", sq("H=40\n"), sq("D=12\n"), -1, 1'b0, none);
      run_scn("contend2", sq("H=41\n"), sq("D=13\n"), -1, 1'b0, none);
      run_scn("single", sq("T=25\n"), none, -1, 1'b0, none);
      run_scn("no_interleave", sq("RH=55%\n"), none, 2, 1'b1, sq("B\n"));

      a0 = {};
      for (int i = 0; i < MAXB + 2; i++) a0.push_back(rnd_byte(1'b0));
      run_scn("burst", a0, sq("A\n"), -1, 1'b0, none);

      a0 = {};
      a0.push_back(8'h31);
      a0.push_back(8'h32);
      run_scn("underflow", a0, none, -1, 1'b0, none);
      a0 = {};
      a0.push_back(8'h33);
      run_scn("underflow_late", a0, none, -1, 1'b0, none);

      for (int r = 0; r < 12; r++) begin
         int l0, l1, k;
         logic isrc;
         a0 = {};
         a1 = {};
         ib = {};
         l0 = $urandom_range(0, 6);
         l1 = $urandom_range(0, 6);
         if (l0 + l1 == 0) l0 = 1;
         for (int i = 0; i < l0; i++) a0.push_back(rnd_byte(1'b1));
         for (int i = 0; i < l1; i++) a1.push_back(rnd_byte(1'b1));
         k = -1;
         isrc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(1, l0 + l1);
            for (int i = 0; i < $urandom_range(1, 3); i++)
               ib.push_back(rnd_byte(1'b1));
         end
         run_scn($sformatf("random%0d", r), a0, a1, k, isrc, ib);
      end

      // Reset while a byte is on the wire.
      a0 = {};
      for (int i = 0; i < 10; i++) a0.push_back(rnd_byte(1'b0));
      a0.push_back(EOP);
      @(negedge clk);
      scn_cnt = 0;
      inj_k = -1;
      model(a0, sq("C\n"), -1, 1'b0, none);
      foreach (a0[i]) s0q.push_back(a0[i]);
      s1q.push_back(8'h43);
      s1q.push_back(EOP);
      n = 0;
      while (scn_cnt < 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_byte2", int'(scn_cnt >= 2), 1);
      n = 0;
      while (!tx_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_busy_seen", int'(tx_busy), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_grant", int'(grant), 0);
      chk("midrst_tx_start", int'(tx_start), 0);
      chk("midrst_pops", int'({pop1, pop0}), 0);
      chk("midrst_tx_data", int'(tx_data), 0);
      expq.delete();
      m_last = 1'b1;
      b0 = f0q;
      foreach (s0q[i]) b0.push_back(s0q[i]);
      b1 = f1q;
      foreach (s1q[i]) b1.push_back(s1q[i]);
      model(b0, b1, -1, 1'b0, none);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rst_fall_cyc = cyc;
      wait_idle("rst_restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
